// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment code link: receiver FSM states and segment codes.
// Code bit 7 is dp, bits 6..0 are segments a..g.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, DATA, STOP} rx_state_t;

  localparam logic [7:0] SEG_ZERO  = 8'h7E;
  localparam logic [7:0] SEG_ONE   = 8'h30;
  localparam logic [7:0] SEG_TWO   = 8'h6D;
  localparam logic [7:0] SEG_THREE = 8'h79;
  localparam logic [7:0] SEG_FOUR  = 8'h33;
  localparam logic [7:0] SEG_FIVE  = 8'h5B;
  localparam logic [7:0] SEG_SIX   = 8'h5F;
  localparam logic [7:0] SEG_SEVEN = 8'h70;
  localparam logic [7:0] SEG_EIGHT = 8'h7F;
  localparam logic [7:0] SEG_NINE  = 8'h7B;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_HEX_A = 8'h77;
  localparam logic [7:0] SEG_HEX_B = 8'h1F;
  localparam logic [7:0] SEG_HEX_C = 8'h4E;
  localparam logic [7:0] SEG_HEX_D = 8'h3D;
  localparam logic [7:0] SEG_HEX_E = 8'h4F;
  localparam logic [7:0] SEG_HEX_F = 8'h47;

endpackage

// File: rtl/seg7_decode.sv
// Segment pattern -> digit lookup, combinational, no backpressure.
// SEG_HEX_EN adds the A..F glyphs to the table; otherwise they miss like any unknown pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] code,
  output logic       hit,
  output logic       blank,
  output logic [3:0] digit
);

  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    digit = 4'd0;
    // dp is not part of the glyph, so lookup compares with bit 7 forced low
    case ({1'b0, code})
      SEG_ZERO:  digit = 4'd0;
      SEG_ONE:   digit = 4'd1;
      SEG_TWO:   digit = 4'd2;
      SEG_THREE: digit = 4'd3;
      SEG_FOUR:  digit = 4'd4;
      SEG_FIVE:  digit = 4'd5;
      SEG_SIX:   digit = 4'd6;
      SEG_SEVEN: digit = 4'd7;
      SEG_EIGHT: digit = 4'd8;
      SEG_NINE:  digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
`ifdef SEG_HEX_EN
      SEG_HEX_A: digit = 4'hA;
      SEG_HEX_B: digit = 4'hB;
      SEG_HEX_C: digit = 4'hC;
      SEG_HEX_D: digit = 4'hD;
      SEG_HEX_E: digit = 4'hE;
      SEG_HEX_F: digit = 4'hF;
`endif
      default:   hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_code_rx.sv
// Deserialises framed 8-bit segment codes (start 1, MSB first, stop 0) into a digit.
// Latency: results and pulses one cycle after the stop bit; no backpressure, bit_valid paces input.
// SEG_HEX_EN (in seg7_decode) extends the accepted glyphs with A..F.
module seg_code_rx
  import seg_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int NBITS_CNT = 8
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [3:0]           digit,
  output logic                 blank,
  output logic                 dp,
  output logic [7:0]           code_q,
  output logic                 digit_valid,
  output logic                 code_err,
  output logic                 frame_err,
  output logic [NBITS_CNT-1:0] frame_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  rx_state_t     state_q, state_d;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_cnt_q;
  logic [TW-1:0] idle_cnt_q;

  logic shift_en, frame_done, stop_bad, tmo;
  logic dec_hit, dec_blank;
  logic [3:0] dec_digit;

  seg7_decode u_decode (
    .code  (shreg_q[6:0]),
    .hit   (dec_hit),
    .blank (dec_blank),
    .digit (dec_digit)
  );

  always_comb begin
    state_d    = state_q;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    tmo        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_valid && bit_in) state_d = DATA;
      end
      DATA: begin
        if (bit_valid) begin
          shift_en = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else if (idle_cnt_q == TMAX) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      STOP: begin
        if (bit_valid) begin
          if (bit_in) stop_bad   = 1'b1;
          else        frame_done = 1'b1;
          state_d = IDLE;
        end else if (idle_cnt_q == TMAX) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      idle_cnt_q  <= '0;
      digit       <= 4'd0;
      blank       <= 1'b0;
      dp          <= 1'b0;
      code_q      <= 8'h00;
      digit_valid <= 1'b0;
      code_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      digit_valid <= frame_done && dec_hit;
      code_err    <= frame_done && !dec_hit;
      frame_err   <= stop_bad || tmo;

      if (state_q == IDLE)  bit_cnt_q <= 3'd0;
      else if (shift_en)    bit_cnt_q <= bit_cnt_q + 3'd1;
      if (shift_en)         shreg_q   <= {shreg_q[6:0], bit_in};

      // Gap counter only runs inside a frame and restarts on every accepted bit
      if (state_q != IDLE && !bit_valid && !tmo) idle_cnt_q <= idle_cnt_q + 1'b1;
      else                                       idle_cnt_q <= '0;

      if (frame_done) begin
        code_q <= shreg_q;
        if (dec_hit) begin
          digit     <= dec_digit;
          blank     <= dec_blank;
          dp        <= shreg_q[7];
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_code_rx.sv
// Randomised self-checking bench for seg_code_rx against a table-driven frame model.
module tb_seg_code_rx;

  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [3:0] digit;
  logic       blank, dp, digit_valid, code_err, frame_err;
  logic [7:0] code_q;
  logic [7:0] frame_cnt;

  seg_code_rx #(.TIMEOUT(16), .NBITS_CNT(8)) dut (
    .clk_2       (clk_2),
    .reset_n     (reset_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .digit       (digit),
    .blank       (blank),
    .dp          (dp),
    .code_q      (code_q),
    .digit_valid (digit_valid),
    .code_err    (code_err),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_2 = ~clk_2;

  int total = 0;
  int bad = 0;

`ifdef SEG_HEX_EN
  localparam int NSYM = 16;
`else
  localparam int NSYM = 10;
`endif

  // Glyph for value i, i = 0..15
  logic [7:0] glyph [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                             8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h4E, 8'h3D, 8'h4F, 8'h47};

  // Reference state
  logic [3:0] e_digit;
  logic       e_blank, e_dp, e_dv, e_ce, e_fe;
  logic [7:0] e_code, e_cnt;

  logic [24:0] obs;
  assign obs = {digit, blank, dp, code_q, digit_valid, code_err, frame_err, frame_cnt};

  function automatic logic [24:0] exp_vec();
    return {e_digit, e_blank, e_dp, e_code, e_dv, e_ce, e_fe, e_cnt};
  endfunction

  // Returns glyph value, 16 for blank, -1 for unknown
  function automatic int ref_decode(input logic [7:0] c);
    logic [7:0] g;
    if (c[6:0] == 7'h00) return 16;
    for (int i = 0; i < NSYM; i++) begin
      g = glyph[i];
      if (g[6:0] == c[6:0]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    e_digit = 4'd0; e_blank = 1'b0; e_dp = 1'b0; e_code = 8'h00;
    e_dv = 1'b0; e_ce = 1'b0; e_fe = 1'b0; e_cnt = 8'h00;
  endtask

  task automatic model_idle();
    e_dv = 1'b0; e_ce = 1'b0; e_fe = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] c, input logic stop);
    int r;
    model_idle();
    if (stop) begin
      e_fe = 1'b1;
    end else begin
      r = ref_decode(c);
      e_code = c;
      if (r < 0) begin
        e_ce = 1'b1;
      end else begin
        e_dv    = 1'b1;
        e_blank = (r == 16);
        e_digit = (r == 16) ? 4'd0 : 4'(r);
        e_dp    = c[7];
        e_cnt   = e_cnt + 8'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom_range(0, 1));
      tick();
    end
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Drives a whole frame; returns #1 after the stop-bit edge
  task automatic send_frame(input logic [7:0] c, input logic stop, input int gmax);
    send_bit(1'b1, $urandom_range(0, gmax));
    for (int i = 7; i >= 0; i--) send_bit(c[i], $urandom_range(0, gmax));
    send_bit(stop, $urandom_range(0, gmax));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    model_reset();
    total++;
    if (obs !== 25'd0) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs, 25'd0);
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL reset_release got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_digit_zero();
    send_frame(8'h7E, 1'b0, 0);
    model_frame(8'h7E, 1'b0);
    total++;
    if (digit !== 4'd0 || digit_valid !== 1'b1 || frame_cnt !== 8'd1 || code_q !== 8'h7E) begin
      bad++; $display("FAIL digit_zero got digit=%h dv=%b cnt=%0d code=%h want 0 1 1 7e",
                      digit, digit_valid, frame_cnt, code_q);
    end
    tick();
    model_idle();
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL pulse_one_cycle got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hB0, 1'b0, 0);
    model_frame(8'hB0, 1'b0);
    total++;
    if (digit !== 4'd1 || dp !== 1'b1 || digit_valid !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL b2b_first got=%h want=%h", obs, exp_vec());
    end
    send_frame(8'h6D, 1'b0, 0);
    model_frame(8'h6D, 1'b0);
    total++;
    if (digit !== 4'd2 || dp !== 1'b0 || frame_cnt !== 8'd3 || obs !== exp_vec()) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_hex();
    send_frame(8'h77, 1'b0, 1);
    model_frame(8'h77, 1'b0);
    total++;
`ifdef SEG_HEX_EN
    if (digit !== 4'hA || digit_valid !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL hex_a got=%h want=%h", obs, exp_vec());
    end
`else
    if (code_err !== 1'b1 || digit !== 4'd2 || code_q !== 8'h77 || obs !== exp_vec()) begin
      bad++; $display("FAIL hex_a_unknown got=%h want=%h", obs, exp_vec());
    end
`endif
  endtask

  task automatic test_stop_err();
    logic [7:0] code_before;
    code_before = e_code;
    send_frame(8'h5B, 1'b1, 1);
    model_frame(8'h5B, 1'b1);
    total++;
    if (frame_err !== 1'b1 || code_q !== code_before || obs !== exp_vec()) begin
      bad++; $display("FAIL stop_err got=%h want=%h", obs, exp_vec());
    end
    send_frame(8'h5B, 1'b0, 1);
    model_frame(8'h5B, 1'b0);
    total++;
    if (digit !== 4'd5 || obs !== exp_vec()) begin
      bad++; $display("FAIL after_stop_err got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_timeout();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    model_idle();
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL timeout_early got=%h want=%h", obs, exp_vec());
    end
    tick();
    e_fe = 1'b1;
    total++;
    if (frame_err !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL timeout_fire got=%h want=%h", obs, exp_vec());
    end
    tick();
    model_idle();
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL timeout_clear got=%h want=%h", obs, exp_vec());
    end
    send_frame(8'h33, 1'b0, 2);
    model_frame(8'h33, 1'b0);
    total++;
    if (digit !== 4'd4 || obs !== exp_vec()) begin
      bad++; $display("FAIL after_timeout got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b1, 0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 0);
    reset_n = 1'b0;
    tick();
    model_reset();
    total++;
    if (obs !== 25'd0) begin
      bad++; $display("FAIL reset_midframe got=%h want=%h", obs, 25'd0);
    end
    reset_n = 1'b1;
    send_frame(8'h79, 1'b0, 1);
    model_frame(8'h79, 1'b0);
    total++;
    if (digit !== 4'd3 || frame_cnt !== 8'd1 || obs !== exp_vec()) begin
      bad++; $display("FAIL after_reset_frame got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic       stop;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          c = glyph[$urandom_range(0, 15)];
          c[7] = 1'($urandom_range(0, 1));
        end
        2:       c = 8'($urandom);
        default: c = {1'($urandom_range(0, 1)), 7'h00};
      endcase
      stop = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bit_valid = 1'b1; bit_in = 1'b0;
        tick();
        bit_valid = 1'b0;
        model_idle();
      end
      send_frame(c, stop, 3);
      model_frame(c, stop);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random_frame n=%0d code=%h stop=%b got=%h want=%h",
                        n, c, stop, obs, exp_vec());
      end
      if ($urandom_range(0, 1) == 0) begin
        tick();
        model_idle();
        total++;
        if (obs !== exp_vec()) begin
          bad++; $display("FAIL random_idle n=%0d got=%h want=%h", n, obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] c;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 256; n++) begin
      c = glyph[$urandom_range(0, 9)];
      c[7] = 1'($urandom_range(0, 1));
      send_frame(c, 1'b0, 0);
      model_frame(c, 1'b0);
      if (n == 254) begin
        total++;
        if (frame_cnt !== 8'd255) begin
          bad++; $display("FAIL wrap_255 got=%0d want=255", frame_cnt);
        end
      end
    end
    total++;
    if (frame_cnt !== 8'd0 || digit_valid !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL wrap_zero got=%h want=%h", obs, exp_vec());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_digit_zero();
    test_back_to_back();
    test_hex();
    test_stop_err();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
